dispatcher_rr: RTL and testbench
================================

DISPATCHER_RR -- requirements
Module: dispatcher_rr

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, the data beat width in bits.
REQ-002 SHALL have parameter PRIORITY_0, default 1; 1 means output 0 is preferred after reset, any other value means output 1 is preferred.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1), in_data (input, DWIDTH) and in_ready (output, 1): the upstream valid/ready slave.
REQ-006 SHALL have ports out_0_valid (output, 1), out_0_data (output, DWIDTH) and out_0_ready (input, 1): downstream master 0.
REQ-007 SHALL have ports out_1_valid (output, 1), out_1_data (output, DWIDTH) and out_1_ready (input, 1): downstream master 1.

Function
REQ-008 SHALL hold one registered slot per output; out_k_valid and out_k_data SHALL be driven only from slot k.
REQ-009 SHALL treat a transfer as occurring on a port when valid and ready are both high at a clock edge.
REQ-010 SHALL define can_k = ~out_k_valid | out_k_ready, so a slot being drained this cycle can accept a new beat.
REQ-011 SHALL drive in_ready = can_0 | can_1, combinationally, with no dependency on in_valid.
REQ-012 SHALL, on an input transfer with only one can_k high, load the beat into that slot.
REQ-013 SHALL, on an input transfer with both can_k high, load the beat into the slot selected by rr_ptr.
REQ-014 SHALL set rr_ptr to the output not loaded after every input transfer, and hold rr_ptr otherwise.
REQ-015 SHALL give a latency of exactly 1 cycle: a beat accepted at edge N is visible on out_k_valid/out_k_data after edge N.
REQ-016 SHALL clear slot k valid on an output transfer unless the same edge reloads slot k; a simultaneous drain and reload SHALL keep out_k_valid high with the new data.
REQ-017 SHALL never write the same beat into both slots, never drop a beat, and never duplicate a beat.
REQ-018 SHALL keep out_k_data and out_k_valid stable while out_k_valid=1 and out_k_ready=0 (no retraction).
REQ-019 SHALL sustain one beat per cycle when at least one output accepts every cycle.
REQ-020 SHALL, when both slots are full and neither output is ready, drive in_ready=0.

Reset
REQ-021 SHALL, while rst=1 at an edge, clear both slot valid bits, so out_0_valid=0 and out_1_valid=0.
REQ-022 SHALL, while rst=1, reset rr_ptr to 0 if PRIORITY_0==1 and to 1 otherwise.
REQ-023 SHALL reset data registers to all zeros.
REQ-024 SHALL discard any buffered beats when reset is asserted mid-operation; in_ready SHALL follow REQ-011 from the cleared state.

Configuration
REQ-025 SHALL, with macro DISPATCHER_RR_STATS_EN defined, add output ports count_0 and count_1 (each 16 bits), counting output transfers on out_0 and out_1 respectively.
REQ-026 SHALL reset count_0 and count_1 to 0, increment each by 1 per output transfer, and wrap from 0xFFFF to 0x0000.
REQ-027 SHALL, without DISPATCHER_RR_STATS_EN, omit the counters and their ports entirely, with otherwise identical behaviour.

Verification
REQ-028 SHALL cover reset preference: PRIORITY_0=1, both outputs ready, send beats 0x11,0x22,0x33 -> out_0 gets 0x11,0x33 and out_1 gets 0x22, each one cycle after acceptance.
REQ-029 SHALL cover a stalled output: out_0_ready=0 with slot 0 full, send 0xA5 -> 0xA5 goes to out_1; a next beat 0x5A with slot 1 also stalled gives in_ready=0 until either output becomes ready.
REQ-030 SHALL cover drain and reload on one edge: slot 0 holds 0x01, out_0_ready=1, out_1 stalled and full, input 0x02 -> out_0_valid stays 1 and out_0_data becomes 0x02.
REQ-031 SHALL cover reset mid-operation: both slots full, rst pulsed for 1 cycle -> both out_k_valid=0, in_ready=1, and the first beat afterwards goes to the preferred output.
REQ-032 SHALL cover the stats option: with DISPATCHER_RR_STATS_EN defined and count_0 preset to 0xFFFF via 65535 transfers, one more out_0 transfer gives count_0=0x0000 while count_1 is unchanged.

Source files
------------

// File: rtl/dispatcher_rr_if.sv
// Valid/ready bundle for dispatcher_rr: one upstream slave channel and two downstream master channels.
// The slave modport is the dispatcher's view; master is the environment's view.
interface dispatcher_rr_if #(
    parameter int DWIDTH = 8
);
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic              out_0_valid;
    logic [DWIDTH-1:0] out_0_data;
    logic              out_0_ready;
    logic              out_1_valid;
    logic [DWIDTH-1:0] out_1_data;
    logic              out_1_ready;

    modport slave (
        input  in_valid, in_data, out_0_ready, out_1_ready,
        output in_ready, out_0_valid, out_0_data, out_1_valid, out_1_data
    );

    modport master (
        output in_valid, in_data, out_0_ready, out_1_ready,
        input  in_ready, out_0_valid, out_0_data, out_1_valid, out_1_data
    );
endinterface

// File: rtl/dispatcher_rr.sv
// 1-in / 2-out round-robin dispatcher with one registered slot per output.
// Optional transfer counters count_0/count_1 under macro DISPATCHER_RR_STATS_EN.
module dispatcher_rr #(
    parameter int DWIDTH     = 8,
    parameter int PRIORITY_0 = 1
) (
    input  logic                clk,
    input  logic                rst,
    dispatcher_rr_if.slave      bus
`ifdef DISPATCHER_RR_STATS_EN
    ,
    output logic [15:0]         count_0,
    output logic [15:0]         count_1
`endif
);
    localparam logic RST_PTR = (PRIORITY_0 == 1) ? 1'b0 : 1'b1;

    logic [1:0]             r_vld;
    logic [1:0][DWIDTH-1:0] r_data;
    logic                   r_rr_ptr;

    logic [1:0] w_ordy;
    logic [1:0] w_can;
    logic [1:0] w_drain;
    logic [1:0] w_load;
    logic       w_acc;
    logic       w_sel1;

    assign w_ordy  = {bus.out_1_ready, bus.out_0_ready};
    assign w_can   = ~r_vld | w_ordy;
    assign w_drain = r_vld & w_ordy;
    assign w_acc   = bus.in_valid & bus.in_ready;

    // Slot 1 wins when it is the only free slot, or both are free and the pointer says so.
    assign w_sel1 = w_can[1] & (~w_can[0] | r_rr_ptr);
    assign w_load = {w_acc & w_sel1, w_acc & ~w_sel1};

    assign bus.in_ready    = w_can[0] | w_can[1];
    assign bus.out_0_valid = r_vld[0];
    assign bus.out_0_data  = r_data[0];
    assign bus.out_1_valid = r_vld[1];
    assign bus.out_1_data  = r_data[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld    <= '0;
            r_data   <= '0;
            r_rr_ptr <= RST_PTR;
        end else begin
            for (int k = 0; k < 2; k++) begin
                // A reload on the draining edge keeps the slot valid with the new beat.
                if (w_load[k]) begin
                    r_vld[k]  <= 1'b1;
                    r_data[k] <= bus.in_data;
                end else if (w_drain[k]) begin
                    r_vld[k] <= 1'b0;
                end
            end
            if (w_acc) begin
                r_rr_ptr <= ~w_sel1;
            end
        end
    end

`ifdef DISPATCHER_RR_STATS_EN
    logic [1:0][15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_drain[k]) begin
                    r_cnt[k] <= r_cnt[k] + 16'd1;
                end
            end
        end
    end

    assign count_0 = r_cnt[0];
    assign count_1 = r_cnt[1];
`endif

endmodule

// File: tb/tb_dispatcher_rr.sv
// Self-checking bench for dispatcher_rr: directed scenarios plus random traffic against a
// per-cycle reference model of the dispatch rules.
module tb_dispatcher_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;

    dispatcher_rr_if #(.DWIDTH(8)) ifc ();

`ifdef DISPATCHER_RR_STATS_EN
    logic [15:0] count_0, count_1;
    dispatcher_rr #(.DWIDTH(8), .PRIORITY_0(1)) dut (
        .clk(clk), .rst(rst), .bus(ifc), .count_0(count_0), .count_1(count_1));
`else
    dispatcher_rr #(.DWIDTH(8), .PRIORITY_0(1)) dut (
        .clk(clk), .rst(rst), .bus(ifc));
`endif

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: what each output slot holds, who is preferred, transfer counts.
    logic        mv[2];
    logic [7:0]  md[2];
    int          mptr;
    logic [15:0] mcnt[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mv[0] = 1'b0; mv[1] = 1'b0;
        md[0] = 8'h00; md[1] = 8'h00;
        mptr = 0;
        mcnt[0] = 16'h0; mcnt[1] = 16'h0;
    endtask

    // One clock: drive after negedge, compare against the model, advance the model over the edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic r0, input logic r1,
                        input logic rs);
        logic can0, can1, acc;
        int   tgt;
        @(negedge clk);
        ifc.in_valid    = iv;
        ifc.in_data     = d;
        ifc.out_0_ready = r0;
        ifc.out_1_ready = r1;
        rst             = rs;
        #1;
        can0 = !mv[0] || r0;
        can1 = !mv[1] || r1;
        chk("in_ready", 32'(ifc.in_ready), 32'(can0 || can1));
        chk("out_0_valid", 32'(ifc.out_0_valid), 32'(mv[0]));
        chk("out_1_valid", 32'(ifc.out_1_valid), 32'(mv[1]));
        if (mv[0]) chk("out_0_data", 32'(ifc.out_0_data), 32'(md[0]));
        if (mv[1]) chk("out_1_data", 32'(ifc.out_1_data), 32'(md[1]));
`ifdef DISPATCHER_RR_STATS_EN
        chk("count_0", 32'(count_0), 32'(mcnt[0]));
        chk("count_1", 32'(count_1), 32'(mcnt[1]));
`endif
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            acc = iv && (can0 || can1);
            tgt = (can0 && can1) ? mptr : (can0 ? 0 : 1);
            if (mv[0] && r0) begin mv[0] = 1'b0; mcnt[0] = mcnt[0] + 16'd1; end
            if (mv[1] && r1) begin mv[1] = 1'b0; mcnt[1] = mcnt[1] + 16'd1; end
            if (acc) begin
                mv[tgt] = 1'b1;
                md[tgt] = d;
                mptr    = 1 - tgt;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        ifc.in_valid = 1'b0; ifc.in_data = 8'h00;
        ifc.out_0_ready = 1'b0; ifc.out_1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst out_0_valid", 32'(ifc.out_0_valid), 32'd0);
        chk("rst out_1_valid", 32'(ifc.out_1_valid), 32'd0);
        chk("rst out_0_data", 32'(ifc.out_0_data), 32'd0);
        chk("rst out_1_data", 32'(ifc.out_1_data), 32'd0);
        chk("rst in_ready", 32'(ifc.in_ready), 32'd1);

        // Reset preference: 0x11 -> out_0, 0x22 -> out_1, 0x33 -> out_0
        step(1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
        chk("pref o0 11", {ifc.out_0_valid, ifc.out_0_data}, {1'b1, 8'h11});
        step(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
        chk("pref o1 22", {ifc.out_1_valid, ifc.out_1_data}, {1'b1, 8'h22});
        chk("pref o0 empty", 32'(ifc.out_0_valid), 32'd0);
        step(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
        chk("pref o0 33", {ifc.out_0_valid, ifc.out_0_data}, {1'b1, 8'h33});
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Stalled output steers traffic, then both stalled blocks input
        do_reset();
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("stall o1 A5", {ifc.out_1_valid, ifc.out_1_data}, {1'b1, 8'hA5});
        chk("stall o0 held", {ifc.out_0_valid, ifc.out_0_data}, {1'b1, 8'h01});
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("stall in_ready", 32'(ifc.in_ready), 32'd0);
        chk("stall o1 held", {ifc.out_1_valid, ifc.out_1_data}, {1'b1, 8'hA5});
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        chk("unstall o1 5A", {ifc.out_1_valid, ifc.out_1_data}, {1'b1, 8'h5A});

        // Drain and reload slot 0 on one edge
        do_reset();
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        chk("reload o0", {ifc.out_0_valid, ifc.out_0_data}, {1'b1, 8'h02});
        chk("reload o1 held", {ifc.out_1_valid, ifc.out_1_data}, {1'b1, 8'hEE});

        // Reset mid-operation with both slots full
        do_reset();
        chk("midrst o0_valid", 32'(ifc.out_0_valid), 32'd0);
        chk("midrst o1_valid", 32'(ifc.out_1_valid), 32'd0);
        chk("midrst in_ready", 32'(ifc.in_ready), 32'd1);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        chk("midrst pref o0", {ifc.out_0_valid, ifc.out_0_data}, {1'b1, 8'h77});

        // Random traffic against the model, with occasional resets
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 99) == 0));
        end

`ifdef DISPATCHER_RR_STATS_EN
        // Push count_0 to 0xFFFF, then one more out_0 transfer must wrap it
        do_reset();
        for (int i = 0; i < 70000 && mcnt[0] != 16'hFFFF; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        end
        chk("cnt0 preset", 32'(count_0), 32'hFFFF);
        begin
            logic [15:0] c1;
            c1 = count_1;
            step(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
            chk("cnt0 wrap", 32'(count_0), 32'h0000);
            chk("cnt1 steady", 32'(count_1), 32'(c1));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
